icb_sram_ctrl: RTL and testbench



---
 rtl/icb_pkg.sv | 20 ++
 rtl/icb_sram_ctrl_if.sv | 30 +++
 rtl/sram_sp_bwe.sv | 31 +++
 rtl/icb_sram_ctrl.sv | 100 ++++++++++
 tb/tb_icb_sram_ctrl.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/icb_pkg.sv
// Shared ICB definitions: width helper, response record and default SRAM size.
package icb_pkg;

  localparam int unsigned IcbSramDepth = 4096;
  localparam int unsigned IcbDw = 32;

  typedef struct packed {
    logic             err;
    logic [IcbDw-1:0] rdata;
  } icb_rsp_t;

  // Bits needed to index n items; never less than 1 so ports stay legal.
  function automatic int unsigned clogb2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/icb_sram_ctrl_if.sv
// ICB command/response channel bundle with bus-master and bus-slave views.
interface icb_sram_ctrl_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) ();

  logic            icb_cmd_valid;
  logic            icb_cmd_ready;
  logic [AW-1:0]   icb_cmd_addr;
  logic            icb_cmd_read;
  logic [DW-1:0]   icb_cmd_wdata;
  logic [DW/8-1:0] icb_cmd_wmask;
  logic            icb_rsp_valid;
  logic            icb_rsp_ready;
  logic            icb_rsp_err;
  logic [DW-1:0]   icb_rsp_rdata;

  modport master (
    output icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask,
    output icb_rsp_ready,
    input  icb_cmd_ready, icb_rsp_valid, icb_rsp_err, icb_rsp_rdata
  );

  modport slave (
    input  icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask,
    input  icb_rsp_ready,
    output icb_cmd_ready, icb_rsp_valid, icb_rsp_err, icb_rsp_rdata
  );

endinterface

// File: rtl/sram_sp_bwe.sv
// Single-port RAM with per-byte write enables and a registered read port; no reset.
module sram_sp_bwe
  import icb_pkg::*;
#(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = IcbSramDepth
) (
  input  logic                      clk,
  input  logic                      en,
  input  logic                      we,
  input  logic [DW/8-1:0]           be,
  input  logic [clogb2(DEPTH)-1:0]  addr,
  input  logic [DW-1:0]             wdata,
  output logic [DW-1:0]             rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < DW / 8; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/icb_sram_ctrl.sv
// ICB slave around a byte-writable SRAM: credit-based cmd backpressure, in-order
// responses through a bypassable FIFO, and out-of-range error with write suppression.
module icb_sram_ctrl
  import icb_pkg::*;
#(
  parameter int unsigned DW        = 32,
  parameter int unsigned DEPTH     = IcbSramDepth,
  parameter int unsigned AW        = 32,
  parameter int unsigned RSP_DEPTH = 2
) (
  input logic            clk,
  input logic            rst,
  icb_sram_ctrl_if.slave icb
);

  localparam int unsigned OffW  = $clog2(DW / 8);
  localparam int unsigned RamAw = clogb2(DEPTH);
  localparam int unsigned CntW  = clogb2(RSP_DEPTH + 1);
  localparam int unsigned PtrW  = clogb2(RSP_DEPTH);

  typedef struct packed {
    logic          err;
    logic [DW-1:0] rdata;
  } rsp_t;

  logic [AW-1:0]   word_idx;
  logic            cmd_err, accept, rsp_hs, push, pop, fifo_empty;
  logic [CntW-1:0] out_cnt_q, fifo_cnt_q;
  logic [PtrW-1:0] rptr_q, wptr_q;
  logic            pend_q, pend_err_q, pend_rd_q;
  logic [DW-1:0]   ram_rdata;
  rsp_t            fifo_q [RSP_DEPTH];
  rsp_t            pend_rsp, head_rsp;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign word_idx = icb.icb_cmd_addr >> OffW;
  assign cmd_err  = word_idx >= AW'(DEPTH);

  assign icb.icb_cmd_ready = !rst && (out_cnt_q < CntW'(RSP_DEPTH));
  assign accept            = icb.icb_cmd_valid && icb.icb_cmd_ready;

  sram_sp_bwe #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .en    (accept && !cmd_err),
    .we    (!icb.icb_cmd_read),
    .be    (icb.icb_cmd_wmask),
    .addr  (word_idx[RamAw-1:0]),
    .wdata (icb.icb_cmd_wdata),
    .rdata (ram_rdata)
  );

  // The response of the previous accept is assembled here, with RAM data live.
  always_comb begin
    pend_rsp.err   = pend_err_q;
    pend_rsp.rdata = pend_rd_q ? ram_rdata : '0;
  end

  assign fifo_empty = (fifo_cnt_q == '0);
  assign head_rsp   = fifo_empty ? pend_rsp : fifo_q[rptr_q];

  assign icb.icb_rsp_valid = !fifo_empty || pend_q;
  assign icb.icb_rsp_err   = head_rsp.err;
  assign icb.icb_rsp_rdata = head_rsp.rdata;

  assign rsp_hs = icb.icb_rsp_valid && icb.icb_rsp_ready;
  // Pending response goes straight out only when nothing older is queued and it is taken.
  assign push   = pend_q && !(fifo_empty && icb.icb_rsp_ready);
  assign pop    = !fifo_empty && icb.icb_rsp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_cnt_q  <= '0;
      fifo_cnt_q <= '0;
      rptr_q     <= '0;
      wptr_q     <= '0;
      pend_q     <= 1'b0;
      pend_err_q <= 1'b0;
      pend_rd_q  <= 1'b0;
    end else begin
      out_cnt_q  <= out_cnt_q + CntW'(accept) - CntW'(rsp_hs);
      fifo_cnt_q <= fifo_cnt_q + CntW'(push) - CntW'(pop);
      pend_q     <= accept;
      pend_err_q <= accept && cmd_err;
      pend_rd_q  <= accept && icb.icb_cmd_read && !cmd_err;
      if (push) wptr_q <= ptr_inc(wptr_q);
      if (pop)  rptr_q <= ptr_inc(rptr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr_q] <= pend_rsp;
  end

endmodule

// File: tb/tb_icb_sram_ctrl.sv
// Self-checking bench for icb_sram_ctrl: directed vector table, corner sequences and
// randomized traffic scored against an in-order memory/response model.
module tb_icb_sram_ctrl;
  import icb_pkg::*;

  localparam int unsigned Depth = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   rsp_seen = 0;
  bit   rand_rdy = 1'b0;

  logic [31:0] ref_mem [Depth];
  icb_rsp_t    exp_q [$];

  icb_sram_ctrl_if #(.AW(32), .DW(32)) bus ();

  icb_sram_ctrl #(
    .DW        (32),
    .DEPTH     (Depth),
    .AW        (32),
    .RSP_DEPTH (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .icb (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_accept();
    icb_rsp_t    r;
    logic [31:0] w;
    w       = bus.icb_cmd_addr >> 2;
    r.err   = (w >= Depth);
    r.rdata = '0;
    if (!r.err) begin
      if (bus.icb_cmd_read) r.rdata = ref_mem[w[9:0]];
      else begin
        for (int b = 0; b < 4; b++)
          if (bus.icb_cmd_wmask[b]) ref_mem[w[9:0]][8*b +: 8] = bus.icb_cmd_wdata[8*b +: 8];
      end
    end
    exp_q.push_back(r);
  endtask

  // Scoreboard: credit rule, response presence, order/content and stall stability.
  bit          prev_stall = 1'b0;
  logic [32:0] prev_rsp;
  always @(negedge clk) begin
    icb_rsp_t e;
    if (rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      check("cmd_ready", 64'(bus.icb_cmd_ready), 64'(exp_q.size() < 2));
      check("rsp_valid", 64'(bus.icb_rsp_valid), 64'(exp_q.size() > 0));
      if (prev_stall)
        check("rsp_hold", {31'd0, bus.icb_rsp_valid, bus.icb_rsp_err, bus.icb_rsp_rdata},
              {31'd0, 1'b1, prev_rsp});
      prev_stall = bus.icb_rsp_valid && !bus.icb_rsp_ready;
      prev_rsp   = {bus.icb_rsp_err, bus.icb_rsp_rdata};
      if (bus.icb_rsp_valid && bus.icb_rsp_ready) begin
        rsp_seen++;
        if (exp_q.size() == 0) check("spurious_rsp", 64'd1, 64'd0);
        else begin
          e = exp_q.pop_front();
          check("rsp", 64'({bus.icb_rsp_err, bus.icb_rsp_rdata}), 64'(e));
        end
      end
      if (bus.icb_cmd_valid && bus.icb_cmd_ready) model_accept();
    end
  end

  always @(posedge clk) begin
    #2;
    if (rand_rdy) bus.icb_rsp_ready = ($urandom_range(0, 3) != 0);
  end

  // Present one command from posedge+1 and return at posedge+1 after it is accepted.
  task automatic issue(input logic rd, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] m);
    bit done;
    done = 1'b0;
    bus.icb_cmd_valid = 1'b1;
    bus.icb_cmd_read  = rd;
    bus.icb_cmd_addr  = a;
    bus.icb_cmd_wdata = wd;
    bus.icb_cmd_wmask = m;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      if (bus.icb_cmd_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.icb_cmd_valid = 1'b0;
    if (!done) check("issue_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    bus.icb_cmd_valid = 1'b0;
    bus.icb_rsp_ready = 1'b1;
    for (int c = 0; c < 100 && exp_q.size() > 0; c++) begin
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  typedef struct {
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [13];

  initial begin
    int acc, k, base, bad_rdy, in_win, out_win, stale;
    bus.icb_cmd_valid = 1'b0;
    bus.icb_cmd_read  = 1'b0;
    bus.icb_cmd_addr  = '0;
    bus.icb_cmd_wdata = '0;
    bus.icb_cmd_wmask = '0;
    bus.icb_rsp_ready = 1'b0;

    vecs[0]  = '{1'b0, 32'h10,       32'hA5A5_1234, 4'hF, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 32'h10,       32'h0,         4'h0, 1'b0, 32'hA5A5_1234};
    vecs[2]  = '{1'b0, 32'h10,       32'hFFFF_FFFF, 4'h5, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, 32'h10,       32'h0,         4'h0, 1'b0, 32'hA5FF_12FF};
    vecs[4]  = '{1'b0, 32'h0,        32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 32'h1000,     32'h1111_1111, 4'hF, 1'b1, 32'h0};
    vecs[6]  = '{1'b1, 32'h0,        32'h0,         4'h0, 1'b0, 32'hDEAD_BEEF};
    vecs[7]  = '{1'b1, 32'h1000,     32'h0,         4'h0, 1'b1, 32'h0};
    vecs[8]  = '{1'b0, 32'h14,       32'h7777_7777, 4'h0, 1'b0, 32'h0};
    vecs[9]  = '{1'b1, 32'h13,       32'h0,         4'h0, 1'b0, 32'hA5FF_12FF};
    vecs[10] = '{1'b1, 32'hFFFF_FFFC, 32'h0,        4'h0, 1'b1, 32'h0};
    vecs[11] = '{1'b0, 32'hFFC,      32'h55AA_55AA, 4'hF, 1'b0, 32'h0};
    vecs[12] = '{1'b1, 32'hFFC,      32'h0,         4'h0, 1'b0, 32'h55AA_55AA};

    // Reset state.
    @(negedge clk);
    check("reset_cmd_ready", 64'(bus.icb_cmd_ready), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_rsp", {31'd0, bus.icb_rsp_valid, bus.icb_rsp_err, bus.icb_rsp_rdata}, 64'd0);
    check("reset_ready_after", 64'(bus.icb_cmd_ready), 64'd1);
    @(posedge clk);
    #1 bus.icb_rsp_ready = 1'b1;

    // Directed vectors, each answered exactly one cycle after accept.
    foreach (vecs[i]) begin
      issue(vecs[i].rd, vecs[i].addr, vecs[i].wdata, vecs[i].wmask);
      @(negedge clk);
      check($sformatf("vec%0d", i), {31'd0, bus.icb_rsp_valid, bus.icb_rsp_err, bus.icb_rsp_rdata},
            {31'd0, 1'b1, vecs[i].exp_err, vecs[i].exp_rdata});
      @(posedge clk);
      #1;
    end

    // Read immediately after a write to the same word.
    issue(1'b0, 32'h20, 32'h1234_5678, 4'hF);
    issue(1'b1, 32'h20, 32'h0, 4'h0);
    @(negedge clk);
    check("raw", 64'(bus.icb_rsp_rdata), 64'h1234_5678);
    drain();

    // Backpressure: only two reads fit while responses are stalled.
    for (int w = 0; w < 4; w++) issue(1'b0, 32'(w * 4), 32'(w), 4'hF);
    drain();
    bus.icb_rsp_ready = 1'b0;
    acc  = 0;
    k    = 0;
    base = rsp_seen;
    bus.icb_cmd_valid = 1'b1;
    bus.icb_cmd_read  = 1'b1;
    bus.icb_cmd_addr  = 32'h0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.icb_cmd_ready) acc++;
      @(posedge clk);
      #1 bus.icb_cmd_addr = 32'(acc * 4);
    end
    check("bp_accepted", 64'(acc), 64'd2);
    @(negedge clk);
    check("bp_ready_low", 64'(bus.icb_cmd_ready), 64'd0);
    @(posedge clk);
    #1 bus.icb_rsp_ready = 1'b1;
    k = acc;
    for (int c = 0; c < 20 && (rsp_seen - base) < 4; c++) begin
      @(negedge clk);
      if (bus.icb_cmd_valid && bus.icb_cmd_ready) k++;
      @(posedge clk);
      #1;
      if (k >= 4) bus.icb_cmd_valid = 1'b0;
      else bus.icb_cmd_addr = 32'(k * 4);
    end
    bus.icb_cmd_valid = 1'b0;
    check("bp_delivered", 64'(rsp_seen - base), 64'd4);
    drain();

    // Fill words 0..63 for the later phases.
    for (int w = 0; w < 64; w++) issue(1'b0, 32'(w * 4), $urandom, 4'hF);
    drain();

    // Throughput: 16 back-to-back reads, 16 responses in the next 16 cycles.
    bad_rdy = 0;
    in_win  = 0;
    out_win = 0;
    bus.icb_cmd_valid = 1'b1;
    bus.icb_cmd_read  = 1'b1;
    bus.icb_cmd_addr  = 32'h0;
    for (int c = 0; c <= 17; c++) begin
      @(negedge clk);
      if (c < 16 && !bus.icb_cmd_ready) bad_rdy++;
      if (bus.icb_rsp_valid) begin
        if (c >= 1 && c <= 16) in_win++;
        else out_win++;
      end
      @(posedge clk);
      #1;
      if (c < 15) bus.icb_cmd_addr = 32'((c + 1) * 4);
      else bus.icb_cmd_valid = 1'b0;
    end
    check("tp_ready", 64'(bad_rdy), 64'd0);
    check("tp_rsp", 64'(in_win), 64'd16);
    check("tp_extra", 64'(out_win), 64'd0);

    // Randomized traffic with random response stalls.
    rand_rdy = 1'b1;
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      if ($urandom_range(0, 7) == 0) a = 32'h1000 + ($urandom_range(0, 1023) << 2);
      else a = ($urandom_range(0, 63) << 2) | $urandom_range(0, 3);
      issue(1'(($urandom_range(0, 1))), a, $urandom, 4'($urandom_range(0, 15)));
    end
    rand_rdy = 1'b0;
    drain();

    // Reset with two responses pending and a write presented during reset.
    bus.icb_rsp_ready = 1'b0;
    issue(1'b1, 32'h0, 32'h0, 4'h0);
    issue(1'b1, 32'h4, 32'h0, 4'h0);
    bus.icb_cmd_valid = 1'b1;
    bus.icb_cmd_read  = 1'b0;
    bus.icb_cmd_addr  = 32'h8;
    bus.icb_cmd_wdata = 32'h0000_0BAD;
    bus.icb_cmd_wmask = 4'hF;
    rst = 1'b1;
    @(negedge clk);
    check("rst_cmd_ready", 64'(bus.icb_cmd_ready), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    bus.icb_cmd_valid = 1'b0;
    @(negedge clk);
    check("rst_rsp_valid", 64'(bus.icb_rsp_valid), 64'd0);
    check("rst_ready_after", 64'(bus.icb_cmd_ready), 64'd1);
    @(posedge clk);
    #1 bus.icb_rsp_ready = 1'b1;
    stale = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.icb_rsp_valid) stale++;
    end
    check("rst_no_stale", 64'(stale), 64'd0);
    @(posedge clk);
    #1;
    issue(1'b1, 32'h8, 32'h0, 4'h0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: got timeout, want completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
